fp_op_sequencer: RTL and testbench
==================================

Name: fp_op_sequencer

Overview:
- Multicycle sequencer for the floating-point ALU in the RV32IMF uniciclo datapath.
- On an FP instruction it latches the operands and ALU control code, and holds them stable to the FPALU for the op's latency.
- It stalls PC update for that whole window, then issues a single FP register-file write strobe with the captured result.
- It sits between the control unit/register banks and the FPALU, and gates PC advance in the datapath.

Parameters:
- DATA_W, 32, operand/result width
- CTRL_W, 5, ALU control code width
- LAT_ADDSUB, 4, FPALU cycles for FADD/FSUB (>=1)
- LAT_MUL, 5, cycles for FMUL (>=1)
- LAT_DIV, 16, cycles for FDIV (>=1)
- LAT_SQRT, 16, cycles for FSQRT (>=1)

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous reset, active-high
- iStart  in  1  control decodes an FP-ALU instruction at current PC
- iOp  in  CTRL_W  ALU control code from control unit
- iA  in  DATA_W  FP register read 1
- iB  in  DATA_W  FP register read 2
- oFPControl  out  CTRL_W  latched control code to FPALU
- oFPA  out  DATA_W  latched operand A to FPALU
- oFPB  out  DATA_W  latched operand B to FPALU
- iFPResult  in  DATA_W  FPALU result
- oStall  out  1  freeze PC this cycle
- oResult  out  DATA_W  captured result to FP register write port
- oWriteEn  out  1  FP register write strobe, one cycle
- oDone  out  1  operation completes this cycle
- oStallCount  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, iRST=1): state IDLE, counter 0, oFPControl/oFPA/oFPB/oResult = 0, oWriteEn = oDone = 0; any in-flight op is abandoned with no write.
- States: IDLE, EXEC, DONE (2-bit encoding).
- IDLE, iStart=1 (accept):
  - latch iOp/iA/iB into oFPControl/oFPA/oFPB;
  - load counter with LAT(iOp)-1;
  - next state EXEC.
- IDLE, iStart=0: stay in IDLE; latched registers hold.
- EXEC:
  - counter != 0: decrement;
  - counter == 0: capture iFPResult into oResult; next state DONE.
  - iStart, iA and iB are ignored throughout EXEC.
- DONE:
  - oWriteEn = 1 and oDone = 1 for exactly one cycle;
  - next state IDLE unconditionally;
  - iStart is ignored in DONE. The same instruction is still at PC there, so re-acceptance must not occur.
- oStall is combinational: 1 when (IDLE & iStart) or EXEC; 0 in DONE, so PC advances at the end of DONE.
- Timing: accept at cycle 0 -> oStall high cycles 0..LAT -> DONE at cycle LAT+1 -> IDLE at LAT+2. Instruction occupancy is LAT+2 cycles.
- Latency lookup:
  - FADD/FSUB -> LAT_ADDSUB; FMUL -> LAT_MUL; FDIV -> LAT_DIV; FSQRT -> LAT_SQRT.
  - All other codes (sign-inject, min/max, compare, cvt, move, unknown) -> 1.
- Counter width is clog2 of the max latency; no wrap is possible within an op.
- Back-to-back FP instructions: the second is accepted in the IDLE cycle right after DONE; there is no bubble beyond DONE.
- oResult holds its value until the next capture.
- oFPA/oFPB/oFPControl are stable from the cycle after accept through DONE.

Optional Feature:
- Macro: FPSEQ_PERFCNT_EN.
- Defined: oStallCount is a 32-bit register that increments every cycle oStall=1, wraps 0xFFFFFFFF -> 0, and is cleared by iRST.
- Undefined: oStallCount is tied to 32'h0 and the counter logic is absent.

Decomposition:
- Shared parameters header (alongside the existing Parametros.v defines): FP ALU control codes (OPFADD, OPFSUB, OPFMUL, OPFDIV, OPFSQRT) and sequencer state encodings.
- One sub-module is natural: fpseq_latency_lut. It is combinational: iOp -> latency minus one, parameterised by the LAT_* values.

Test Plan:
- Reset with iStart=1 held: all outputs 0, state IDLE. On release, op accepted on the first edge.
- FADD with LAT_ADDSUB=4, iA=0x3F800000, iB=0x40000000, iFPResult=0x40400000:
  - oStall high cycles 0-4;
  - oWriteEn=1 and oResult=0x40400000 at cycle 5;
  - oStall=0 at cycle 5.
- FSGNJ (latency 1): oStall cycles 0-1, oWriteEn at cycle 2. Then an FDIV accepted at cycle 3 with no extra bubble; its write occurs at cycle 3+17=20.
- FDIV in flight: change iA/iB/iStart mid-EXEC. oFPA/oFPB are unchanged, there is no second accept, and exactly one oWriteEn pulse occurs.
- Assert iRST at cycle 3 of FMUL: outputs clear immediately, with no oWriteEn in the following 10 cycles.
- With FPSEQ_PERFCNT_EN: after an FADD(4) and an FMUL(5), oStallCount=11. Preload near 0xFFFFFFFF to check wrap to 0.

Source files
------------

// File: rtl/fp_op_sequencer_pkg.sv
// rtl/fp_op_sequencer_pkg.sv - shared FP ALU control codes, sequencer states and helpers
package fp_op_sequencer_pkg;

    // FP ALU control codes for the multicycle operations; every other code
    // (sign-inject, min/max, compare, convert, move) completes in one cycle.
    localparam logic [4:0] OPFADD  = 5'd10;
    localparam logic [4:0] OPFSUB  = 5'd11;
    localparam logic [4:0] OPFMUL  = 5'd12;
    localparam logic [4:0] OPFDIV  = 5'd13;
    localparam logic [4:0] OPFSQRT = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } fpseq_state_e;

    function automatic int fpseq_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fpseq_latency_lut.sv
// rtl/fpseq_latency_lut.sv - combinational FP op code to (latency - 1) lookup
//
// Ports:
//   iOp     in   CTRL_W  FP ALU control code
//   oLatM1  out  CNT_W   latency of that op minus one (0 for single-cycle ops)
module fpseq_latency_lut
    import fp_op_sequencer_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter int LAT_ADDSUB = 4,
    parameter int LAT_MUL    = 5,
    parameter int LAT_DIV    = 16,
    parameter int LAT_SQRT   = 16,
    parameter int CNT_W      = 4
) (
    input  logic [CTRL_W-1:0] iOp,
    output logic [CNT_W-1:0]  oLatM1
);

    always_comb begin
        oLatM1 = '0;
        case (iOp)
            CTRL_W'(OPFADD),
            CTRL_W'(OPFSUB):  oLatM1 = CNT_W'(LAT_ADDSUB - 1);
            CTRL_W'(OPFMUL):  oLatM1 = CNT_W'(LAT_MUL - 1);
            CTRL_W'(OPFDIV):  oLatM1 = CNT_W'(LAT_DIV - 1);
            CTRL_W'(OPFSQRT): oLatM1 = CNT_W'(LAT_SQRT - 1);
            default:          oLatM1 = '0;
        endcase
    end

endmodule

// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - multicycle FP ALU sequencer: latch operands, stall PC, single write strobe
//
// Optional feature macro: FPSEQ_PERFCNT_EN (enables the 32-bit stall-cycle counter).
//
// Ports:
//   iCLK, iRST               clock, asynchronous active-high reset
//   iStart, iOp, iA, iB      FP instruction request, control code and operands
//   oFPControl, oFPA, oFPB   latched control/operands held stable to the FPALU
//   iFPResult                FPALU result
//   oStall                   freeze PC this cycle
//   oResult, oWriteEn        captured result and one-cycle FP register write strobe
//   oDone                    operation completes this cycle
//   oStallCount              stall-cycle counter (zero unless FPSEQ_PERFCNT_EN)
module fp_op_sequencer
    import fp_op_sequencer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 5,
    parameter int LAT_ADDSUB = 4,
    parameter int LAT_MUL    = 5,
    parameter int LAT_DIV    = 16,
    parameter int LAT_SQRT   = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic [CTRL_W-1:0] iOp,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    output logic [CTRL_W-1:0] oFPControl,
    output logic [DATA_W-1:0] oFPA,
    output logic [DATA_W-1:0] oFPB,
    input  logic [DATA_W-1:0] iFPResult,
    output logic              oStall,
    output logic [DATA_W-1:0] oResult,
    output logic              oWriteEn,
    output logic              oDone,
    output logic [31:0]       oStallCount
);

    localparam int LAT_MAX = fpseq_max4(LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_SQRT);
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    fpseq_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]  lat_m1;

    fpseq_latency_lut #(
        .CTRL_W     (CTRL_W),
        .LAT_ADDSUB (LAT_ADDSUB),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_SQRT   (LAT_SQRT),
        .CNT_W      (CNT_W)
    ) u_lat_lut (
        .iOp    (iOp),
        .oLatM1 (lat_m1)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        oStall   = 1'b0;
        oWriteEn = 1'b0;
        oDone    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    ctrl_d  = iOp;
                    a_d     = iA;
                    b_d     = iB;
                    cnt_d   = lat_m1;
                    state_d = ST_EXEC;
                    oStall  = 1'b1;
                end
            end
            ST_EXEC: begin
                oStall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d   = iFPResult;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The instruction that started this op is still at PC here, so
                // iStart must not re-accept; PC advances at the end of this cycle.
                oWriteEn = 1'b1;
                oDone    = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs read as idle while reset is held, even with iStart asserted.
        if (iRST) begin
            oStall   = 1'b0;
            oWriteEn = 1'b0;
            oDone    = 1'b0;
        end
    end

    assign oFPControl = ctrl_q;
    assign oFPA       = a_q;
    assign oFPB       = b_q;
    assign oResult    = res_q;

`ifdef FPSEQ_PERFCNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (oStall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign oStallCount = stall_cnt_q;
`else
    assign oStallCount = 32'h0;
`endif

endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb/tb_fp_op_sequencer.sv - randomized self-checking bench for fp_op_sequencer
module tb_fp_op_sequencer;
    import fp_op_sequencer_pkg::*;

    localparam int LAT_ADDSUB = 4;
    localparam int LAT_MUL    = 5;
    localparam int LAT_DIV    = 16;
    localparam int LAT_SQRT   = 16;
    localparam logic [4:0] OP_FSGNJ = 5'd2;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic [4:0]  iOp;
    logic [31:0] iA, iB, iFPResult;
    logic [4:0]  oFPControl;
    logic [31:0] oFPA, oFPB, oResult, oStallCount;
    logic        oStall, oWriteEn, oDone;

    fp_op_sequencer #(
        .DATA_W(32), .CTRL_W(5),
        .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL),
        .LAT_DIV(LAT_DIV), .LAT_SQRT(LAT_SQRT)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp),
        .iA(iA), .iB(iB), .oFPControl(oFPControl), .oFPA(oFPA), .oFPB(oFPB),
        .iFPResult(iFPResult), .oStall(oStall), .oResult(oResult),
        .oWriteEn(oWriteEn), .oDone(oDone), .oStallCount(oStallCount)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an op is described by its accept cycle and latency.
    int          cyc = 0;
    bit          busy = 0;
    int          acc_cyc = 0;
    int          lat = 0;
    logic [4:0]  e_ctrl = '0;
    logic [31:0] e_a = '0, e_b = '0, e_res = '0;
    logic [31:0] e_perf = '0;
    int          we_cnt = 0;
    int          we_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ref_lat(input logic [4:0] op);
        if (op == OPFADD || op == OPFSUB) return LAT_ADDSUB;
        if (op == OPFMUL) return LAT_MUL;
        if (op == OPFDIV) return LAT_DIV;
        if (op == OPFSQRT) return LAT_SQRT;
        return 1;
    endfunction

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 6))
            0: return OPFADD;
            1: return OPFSUB;
            2: return OPFMUL;
            3: return OPFDIV;
            4: return OPFSQRT;
            5: return OP_FSGNJ;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // One clock cycle: drive inputs, check at the negedge, advance the model.
    task automatic step(input logic rst, input logic st, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        bit in_exec, in_done, x_stall, x_we;
        iRST = rst; iStart = st; iOp = op; iA = a; iB = b; iFPResult = res;
        @(negedge iCLK);
        in_exec = busy && (cyc > acc_cyc) && (cyc <= acc_cyc + lat);
        in_done = busy && (cyc == acc_cyc + lat + 1);
        x_stall = !rst && ((!busy && st) || in_exec);
        x_we    = !rst && in_done;
        check("stall", 32'(oStall), 32'(x_stall));
        check("we", 32'(oWriteEn), 32'(x_we));
        check("done", 32'(oDone), 32'(x_we));
        check("ctrl", 32'(oFPControl), rst ? 32'h0 : 32'(e_ctrl));
        check("fpa", oFPA, rst ? 32'h0 : e_a);
        check("fpb", oFPB, rst ? 32'h0 : e_b);
        check("result", oResult, rst ? 32'h0 : e_res);
`ifdef FPSEQ_PERFCNT_EN
        check("stallcnt", oStallCount, rst ? 32'h0 : e_perf);
`else
        check("stallcnt", oStallCount, 32'h0);
`endif
        if (oWriteEn === 1'b1) begin
            we_cnt++;
            we_cyc = cyc;
        end
        if (rst) begin
            busy = 0; e_ctrl = '0; e_a = '0; e_b = '0; e_res = '0; e_perf = '0;
        end else begin
            if (x_stall) e_perf = e_perf + 32'd1;
            if (busy && cyc == acc_cyc + lat) e_res = res;
            if (in_done) begin
                busy = 0;
            end else if (!busy && st) begin
                busy = 1; acc_cyc = cyc; lat = ref_lat(op);
                e_ctrl = op; e_a = a; e_b = b;
            end
        end
        cyc++;
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle_step(input logic rst);
        step(rst, 1'b0, 5'd0, $urandom, $urandom, $urandom);
    endtask

    int base;
    int w0;

    initial begin
        // Reset held with iStart asserted, then accept on the first edge.
        step(1'b1, 1'b1, OPFADD, 32'h3F800000, 32'h40000000, 32'h0);
        step(1'b1, 1'b1, OPFADD, 32'h3F800000, 32'h40000000, 32'h0);

        // FADD 1.0 + 2.0 = 3.0: stall cycles 0..4, write at cycle 5.
        base = cyc;
        step(1'b0, 1'b1, OPFADD, 32'h3F800000, 32'h40000000, 32'h0);
        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h40400000);
        check("fadd_we_cycle", 32'(we_cyc - base), 32'd5);
        check("fadd_result", oResult, 32'h40400000);
        // FMUL following, for the 11-cycle stall total.
        step(1'b0, 1'b1, OPFMUL, 32'h40000000, 32'h40400000, 32'h0);
        for (int i = 1; i <= 6; i++)
            step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h40C00000);
`ifdef FPSEQ_PERFCNT_EN
        check("perf_fadd_fmul", oStallCount, 32'd11);
`else
        check("perf_disabled", oStallCount, 32'd0);
`endif

        // FSGNJ then FDIV: iStart held through EXEC/DONE, accepted at base+3.
        base = cyc;
        w0 = we_cnt;
        step(1'b0, 1'b1, OP_FSGNJ, $urandom, $urandom, 32'h11111111);
        for (int i = 1; i <= 3; i++)
            step(1'b0, 1'b1, OPFDIV, 32'hAAAA0000, 32'h5555FFFF, 32'h22222222);
        for (int i = 4; i <= 21; i++)
            step(1'b0, 1'b0, 5'd0, $urandom, $urandom, 32'h33333333);
        check("fdiv_we_cycle", 32'(we_cyc - base), 32'd20);
        check("sgnj_fdiv_writes", 32'(we_cnt - w0), 32'd2);

        // FDIV with inputs churning mid-EXEC: exactly one write, no re-accept.
        w0 = we_cnt;
        step(1'b0, 1'b1, OPFDIV, 32'h12345678, 32'h9ABCDEF0, $urandom);
        for (int i = 1; i <= 17; i++)
            step(1'b0, 1'b1, rand_op(), $urandom, $urandom, $urandom);
        idle_step(1'b0);
        check("fdiv_single_write", 32'(we_cnt - w0), 32'd1);

        // Reset at cycle 3 of FMUL: no write afterwards.
        w0 = we_cnt;
        step(1'b0, 1'b1, OPFMUL, $urandom, $urandom, $urandom);
        idle_step(1'b0);
        idle_step(1'b0);
        idle_step(1'b1);
        for (int i = 0; i < 10; i++) idle_step(1'b0);
        check("fmul_abort_no_write", 32'(we_cnt - w0), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_op(),
                 $urandom, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
